// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit display scan scheduler.
`timescale 1ns/1ps
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHOW,
    BLANK
  } state_t;

  localparam logic [3:0] CODE_CT   = 4'hC;
  localparam logic [3:0] CODE_F    = 4'hF;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  function automatic logic [3:0] anode_on(input logic [1:0] d);
    return ~(4'b0001 << d);
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Loadable down-counter; done is high while the count sits at zero,
// i.e. during the last cycle of a loaded interval of len+1 cycles.
`timescale 1ns/1ps
module slot_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/display_scan_sched.sv
// Frame scheduler for the shared 4-digit multiplexed display.
// Optional LEADING_ZERO_BLANK_EN: keep digit 1 dark when tens is zero.
`timescale 1ns/1ps
module display_scan_sched
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 8000,
  parameter int BLANK_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Funct_Select,
  input  logic [3:0] Count_CT,
  input  logic [3:0] Count_F,
  output logic [3:0] C_Digit,
  output logic [3:0] C_7Seg,
  output logic       frame_tick
);

  localparam int W = $clog2(REFRESH_DIV);
  localparam logic [W-1:0] SHOW_LD  = W'(REFRESH_DIV - BLANK_CYC - 1);
  localparam logic [W-1:0] BLANK_LD = W'(BLANK_CYC - 1);

  state_t     state;
  logic [1:0] digit;
  logic       sel_q;
  logic [3:0] units_q;
  logic       tens_q;

  logic [3:0] val;
  logic       ge10;
  logic [3:0] units_c;

  assign val     = Funct_Select ? Count_F : Count_CT;
  assign ge10    = (val > 4'd9);
  assign units_c = ge10 ? (val - 4'd10) : val;

  logic         t_load;
  logic [W-1:0] t_len;
  logic         t_done;

  slot_timer #(.W(W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (t_load),
    .len  (t_len),
    .done (t_done)
  );

  always_comb begin
    t_load = 1'b0;
    t_len  = SHOW_LD;
    unique case (state)
      LOAD:  t_load = 1'b1;
      SHOW: begin
        t_load = t_done;
        t_len  = BLANK_LD;
      end
      BLANK: t_load = t_done && (digit != 2'd3);
      default: t_load = 1'b0;
    endcase
  end

  logic [1:0] nxt_digit;
  logic [3:0] nxt_nib;
  logic [3:0] nxt_an;

  always_comb begin
    nxt_digit = digit + 2'd1;
    nxt_nib   = 4'h0;
    nxt_an    = ANODE_OFF;
    unique case (nxt_digit)
      2'd0: begin
        nxt_nib = units_q;
        nxt_an  = anode_on(2'd0);
      end
      2'd1: begin
        nxt_nib = {3'b000, tens_q};
`ifdef LEADING_ZERO_BLANK_EN
        nxt_an  = tens_q ? anode_on(2'd1) : ANODE_OFF;
`else
        nxt_an  = anode_on(2'd1);
`endif
      end
      2'd2: begin
        nxt_nib = sel_q ? CODE_F : CODE_CT;
        nxt_an  = anode_on(2'd2);
      end
      default: begin
        nxt_nib = 4'h0;
        nxt_an  = ANODE_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      digit      <= 2'd0;
      sel_q      <= 1'b0;
      units_q    <= 4'h0;
      tens_q     <= 1'b0;
      C_Digit    <= ANODE_OFF;
      C_7Seg     <= 4'h0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          state      <= LOAD;
          frame_tick <= 1'b1;
        end
        LOAD: begin
          // inputs are taken live here so a select change in LOAD lands this frame
          sel_q   <= Funct_Select;
          units_q <= units_c;
          tens_q  <= ge10;
          digit   <= 2'd0;
          C_Digit <= anode_on(2'd0);
          C_7Seg  <= units_c;
          state   <= SHOW;
        end
        SHOW: begin
          if (t_done) begin
            state   <= BLANK;
            C_Digit <= ANODE_OFF;
          end
        end
        BLANK: begin
          if (t_done) begin
            if (digit == 2'd3) begin
              state      <= LOAD;
              digit      <= 2'd0;
              frame_tick <= 1'b1;
            end else begin
              state   <= SHOW;
              digit   <= nxt_digit;
              C_Digit <= nxt_an;
              C_7Seg  <= nxt_nib;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
